// File: rtl/stream_mux_n_to_1_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : stream_mux_n_to_1_pkg
// Brief    : Shared encodings and helpers for the N:1 streaming multiplexer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package stream_mux_n_to_1_pkg;

    // Selection mode encodings driven on rr_en
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Packet-lock FSM states
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    // Channel index reached by stepping 'off' places upward from 'base', modulo n
    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage : stream_mux_n_to_1_pkg
`default_nettype wire

// File: rtl/stream_mux_n_to_1_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rr_arbiter_n
// Brief    : Combinational round-robin arbiter; searches upward from ptr+1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rr_arbiter_n
    import stream_mux_n_to_1_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_valid
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        // k = NUM_CH revisits ptr itself, so the last winner is lowest priority
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = SEL_W'(wrap_add(int'(ptr), k, NUM_CH));
            if (!grant_valid && req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule : rr_arbiter_n
`default_nettype wire

// File: rtl/stream_mux_n_to_1.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : stream_mux_n_to_1
// Brief    : N:1 handshaked stream mux, manual or round-robin select, one-cycle
//            registered output. Optional packet lock: STREAM_MUX_LOCK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module stream_mux_n_to_1
    import stream_mux_n_to_1_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_last,
`endif
    input  logic [SEL_W-1:0]         sel,
    input  logic                     rr_en,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [SEL_W-1:0] C_PTR_RST = SEL_W'(NUM_CH - 1);

    logic              load_en;
    logic              xfer;
    logic [SEL_W-1:0]  grant;
    logic              grant_valid;
    logic [SEL_W-1:0]  arb_grant;
    logic              arb_valid;
    logic [DATA_W-1:0] grant_data;
    logic              grant_req;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

`ifdef STREAM_MUX_LOCK_EN
    lock_state_e       state_q, state_d;
    logic [SEL_W-1:0]  lk_ch_q, lk_ch_d;
    logic              out_last_q, out_last_d;
    logic              grant_last;
`endif

    rr_arbiter_n #(
        .NUM_CH      (NUM_CH)
    ) u_arb (
        .req         (in_valid),
        .ptr         (rr_ptr_q),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    always_comb begin
        grant       = sel;
        grant_valid = (32'(sel) < NUM_CH);
        if (rr_en == MODE_RR) begin
            grant       = arb_grant;
            grant_valid = arb_valid;
        end
`ifdef STREAM_MUX_LOCK_EN
        // Mid-packet: stay on the locked channel regardless of mode or requests
        if (state_q == ST_LOCKED) begin
            grant       = lk_ch_q;
            grant_valid = 1'b1;
        end
`endif
    end

    // Index by compare so an out-of-range grant never reads past the bus
    always_comb begin
        grant_data = '0;
        grant_req  = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
        grant_last = 1'b0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*DATA_W +: DATA_W];
                grant_req  = in_valid[i];
`ifdef STREAM_MUX_LOCK_EN
                grant_last = in_last[i];
`endif
            end
        end
    end

    assign load_en = !out_valid_q || out_ready;
    assign xfer    = !rst && load_en && grant_valid && grant_req;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ready
        assign in_ready[i] = !rst && load_en && grant_valid && (grant == SEL_W'(i));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            out_valid_d = xfer;
        end
        if (xfer) begin
            out_data_d = grant_data;
            out_ch_d   = grant;
            if (rr_en == MODE_RR) begin
                rr_ptr_d = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= C_PTR_RST;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    always_comb begin
        state_d    = state_q;
        lk_ch_d    = lk_ch_q;
        out_last_d = out_last_q;
        if (xfer) begin
            out_last_d = grant_last;
        end
        case (state_q)
            ST_IDLE: begin
                if (xfer && !grant_last) begin
                    state_d = ST_LOCKED;
                    lk_ch_d = grant;
                end
            end
            ST_LOCKED: begin
                if (xfer && grant_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lk_ch_q    <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lk_ch_q    <= lk_ch_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule : stream_mux_n_to_1
`default_nettype wire

// File: tb/tb_stream_mux_n_to_1.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_stream_mux_n_to_1
// Brief    : Directed bench: 4-channel instance for grant/handshake vectors,
//            3-channel instance for out-of-range select and pointer wrap.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_stream_mux_n_to_1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [31:0] data4;
    logic [3:0]  valid4, ready4;
    logic [1:0]  sel4, och4;
    logic        rr4, ov4, ordy4;
    logic [7:0]  od4;
    // 3-channel instance
    logic [23:0] data3;
    logic [2:0]  valid3, ready3;
    logic [1:0]  sel3, och3;
    logic        rr3, ov3, ordy3;
    logic [7:0]  od3;
`ifdef STREAM_MUX_LOCK_EN
    logic [3:0]  last4;
    logic [2:0]  last3;
    logic        olast4, olast3;
`endif

    stream_mux_n_to_1 #(.NUM_CH(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst(rst), .in_data(data4), .in_valid(valid4), .in_ready(ready4),
`ifdef STREAM_MUX_LOCK_EN
        .in_last(last4), .out_last(olast4),
`endif
        .sel(sel4), .rr_en(rr4), .out_data(od4), .out_ch(och4),
        .out_valid(ov4), .out_ready(ordy4)
    );

    stream_mux_n_to_1 #(.NUM_CH(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst(rst), .in_data(data3), .in_valid(valid3), .in_ready(ready3),
`ifdef STREAM_MUX_LOCK_EN
        .in_last(last3), .out_last(olast3),
`endif
        .sel(sel3), .rr_en(rr3), .out_data(od3), .out_ch(och3),
        .out_valid(ov3), .out_ready(ordy3)
    );

    typedef struct {
        logic       rr_en;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       out_ready;
        logic [3:0] exp_ready;
        logic       exp_ov;
        logic [7:0] exp_data;
        logic [1:0] exp_ch;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out4(input string tag, input logic ov, input logic [7:0] d, input logic [1:0] ch);
        chk({tag, ".out_valid"}, 32'(ov4),  32'(ov));
        chk({tag, ".out_data"},  32'(od4),  32'(d));
        chk({tag, ".out_ch"},    32'(och4), 32'(ch));
    endtask

    vec_t vecs[16];

    initial begin
        // ch0=11 ch1=22 ch2=A5 ch3=44
        vecs[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        vecs[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
        vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        vecs[5]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        vecs[6]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        vecs[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        // manual select; pointer must stay at 1
        vecs[8]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
        vecs[9]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'hA5, 2'd2};
        vecs[10] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
        vecs[11] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
        // backpressure: hold, then load on the consume edge
        vecs[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
        vecs[13] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
        vecs[14] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
        vecs[15] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};

        rst    = 1'b1;
        data4  = {8'h44, 8'hA5, 8'h22, 8'h11};
        valid4 = 4'b1111;
        sel4   = 2'd0;
        rr4    = 1'b1;
        ordy4  = 1'b1;
        data3  = {8'h0C, 8'h0B, 8'h0A};
        valid3 = 3'b000;
        sel3   = 2'd0;
        rr3    = 1'b0;
        ordy3  = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
        last4  = 4'b1111;
        last3  = 3'b111;
`endif

        // Reset held two cycles with every channel valid
        tick;
        chk("rst.in_ready", 32'(ready4), 32'd0);
        tick;
        chk("rst.in_ready2", 32'(ready4), 32'd0);
        chk_out4("rst", 1'b0, 8'h00, 2'd0);
        rst = 1'b0;

        for (int v = 0; v < 16; v++) begin
            rr4    = vecs[v].rr_en;
            sel4   = vecs[v].sel;
            valid4 = vecs[v].valid;
            ordy4  = vecs[v].out_ready;
            #1;
            chk($sformatf("vec%0d.in_ready", v), 32'(ready4), 32'(vecs[v].exp_ready));
            tick;
            chk_out4($sformatf("vec%0d", v), vecs[v].exp_ov, vecs[v].exp_data, vecs[v].exp_ch);
        end

        // Reset while a beat is held: beat dropped, pointer restored
        rst = 1'b1;
        #1;
        chk("midrst.in_ready", 32'(ready4), 32'd0);
        tick;
        chk_out4("midrst", 1'b0, 8'h00, 2'd0);
        rst = 1'b0;
        #1;
        chk("postrst.in_ready", 32'(ready4), 32'b0001);
        tick;
        chk_out4("postrst", 1'b1, 8'h11, 2'd0);
        valid4 = 4'b0000;
        tick;

        // 3-channel: manual select, then out-of-range select drains the beat
        sel3   = 2'd2;
        valid3 = 3'b111;
        #1;
        chk("n3.sel2.in_ready", 32'(ready3), 32'b100);
        tick;
        chk("n3.sel2.out_valid", 32'(ov3), 32'd1);
        chk("n3.sel2.out_data", 32'(od3), 32'h0C);
        chk("n3.sel2.out_ch", 32'(och3), 32'd2);
        sel3  = 2'd3;
        ordy3 = 1'b0;
        #1;
        chk("n3.sel3hold.in_ready", 32'(ready3), 32'd0);
        tick;
        chk("n3.sel3hold.out_valid", 32'(ov3), 32'd1);
        chk("n3.sel3hold.out_data", 32'(od3), 32'h0C);
        ordy3 = 1'b1;
        #1;
        chk("n3.sel3drain.in_ready", 32'(ready3), 32'd0);
        tick;
        chk("n3.sel3drain.out_valid", 32'(ov3), 32'd0);
        chk("n3.sel3drain.out_data", 32'(od3), 32'h0C);
        chk("n3.sel3drain.out_ch", 32'(och3), 32'd2);
        // Round-robin from reset pointer 2 must wrap to channel 0
        rr3 = 1'b1;
        #1;
        chk("n3.rrwrap.in_ready", 32'(ready3), 32'b001);
        tick;
        chk("n3.rrwrap.out_ch", 32'(och3), 32'd0);
        chk("n3.rrwrap.out_data", 32'(od3), 32'h0A);
        valid3 = 3'b000;

`ifdef STREAM_MUX_LOCK_EN
        // ch0 sends a 3-beat packet while ch1 stays valid
        rst = 1'b1;
        tick;
        rst    = 1'b0;
        rr4    = 1'b1;
        ordy4  = 1'b1;
        valid4 = 4'b0011;
        last4  = 4'b0000;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) last4 = 4'b0001;
            #1;
            chk($sformatf("lock.b%0d.in_ready", b), 32'(ready4), 32'b0001);
            tick;
            chk_out4($sformatf("lock.b%0d", b), 1'b1, 8'h11, 2'd0);
            chk($sformatf("lock.b%0d.out_last", b), 32'(olast4), (b == 2) ? 32'd1 : 32'd0);
        end
        valid4 = 4'b0010;
        last4  = 4'b0010;
        #1;
        chk("lock.b3.in_ready", 32'(ready4), 32'b0010);
        tick;
        chk_out4("lock.b3", 1'b1, 8'h22, 2'd1);
        chk("lock.b3.out_last", 32'(olast4), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stream_mux_n_to_1
`default_nettype wire

// File: doc/stream_mux_n_to_1.md
Name: stream_mux_n_to_1

Overview:
- Parametrised N-channel to 1 streaming multiplexer. It is the registered, handshaked successor of the team's 4:1 combinational mux.
- Selection has two modes, chosen at run time:
  - manual: a `sel` input picks the channel, as the old s1/s0 pair did;
  - round-robin: the block arbitrates among channels that have valid data.
- Registered valid/ready output stage with one-cycle latency. Sits between multiple producer streams and a single consumer (UART TX, display driver, etc.).

Parameters:
- NUM_CH, 4, number of input channels; legal range 2..16.
- DATA_W, 8, data width per channel in bits.
- SEL_W, $clog2(NUM_CH), local parameter: width of channel index. Derived from NUM_CH; not overridable.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready.
- sel  input  SEL_W  manual channel select; used only when rr_en=0.
- rr_en  input  1  1 = round-robin arbitration, 0 = manual select.
- out_data  output  DATA_W  registered output data.
- out_ch  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1 (so channel 0 has first priority). While rst=1, in_ready is all 0 (combinationally forced).
- load_en = !out_valid || out_ready. The output register accepts a new beat when it is empty or its current beat is being consumed in the same cycle.
- Grant g, combinational:
  - Manual mode: g = sel.
  - RR mode: g = first channel with in_valid=1, searching upward from rr_ptr+1 modulo NUM_CH. No grant if no valid.
- in_ready[i] = load_en && grant_valid && (g == i). All other channels see in_ready=0.
  - In manual mode, grant_valid = (sel < NUM_CH).
  - In RR mode, grant_valid = |in_valid.
- Transfer occurs on in_valid[g] && in_ready[g]. On the next edge: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- If load_en=1 with no transfer, out_valid <= 0 on the next edge; out_data and out_ch hold their values.
- rr_ptr <= g only on a transfer in RR mode. rr_ptr does not move in manual mode.
- Latency: a beat appears on out_* one cycle after its input handshake. Throughput is one beat per cycle while out_ready=1.
- Backpressure: out_valid=1 with out_ready=0 holds out_data, out_ch and out_valid stable, and forces in_ready all 0.
- A simultaneous consume and load on the same edge is legal; no bubble is inserted.
- sel or rr_en changing mid-stream takes effect on the next grant. The output register is unaffected.
- Out-of-range sel (sel >= NUM_CH, possible when NUM_CH is not a power of 2): no grant, in_ready all 0.
- rst asserted mid-operation: any held output beat is discarded; all reset values are restored on that edge.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN.
- Defined:
  - Adds ports in_last (input, NUM_CH bits) and out_last (output, 1 bit, reset 0, registered alongside out_data).
  - Adds a 2-state FSM:
    - IDLE: normal grant.
    - LOCKED: grant is frozen to the locked channel lk_ch, ignoring sel, rr_en and other valids.
  - IDLE -> LOCKED on a transfer with in_last[g]=0; lk_ch <= g.
  - LOCKED -> IDLE on a transfer with in_last[lk_ch]=1.
  - Reset returns to IDLE.
- Undefined: no in_last/out_last ports, no FSM. Every beat is arbitrated independently.

Decomposition:
- Shared header stream_mux_defs.vh holds:
  - MODE_MANUAL = 1'b0 and MODE_RR = 1'b1 encodings;
  - FSM state encodings ST_IDLE = 1'b0, ST_LOCKED = 1'b1.
- One natural sub-module: rr_arbiter_n. It takes the request vector and rr_ptr and produces the grant index and grant_valid. It is purely combinational.
- The output register and rr_ptr stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_ch=0; after release, first RR grant is channel 0.
- Manual mode: NUM_CH=4, DATA_W=8, rr_en=0, sel=2, in_data ch2=0xA5, all valid, out_ready=1 -> only in_ready[2]=1; out_data=0xA5, out_ch=2 one cycle later.
- Round-robin: rr_en=1, all four valid, out_ready=1 continuously -> out_ch sequence 0,1,2,3,0 with no bubbles. Then only ch1 and ch3 valid -> sequence alternates 1,3,1.
- Backpressure: out_valid=1 with out_data=0x3C, drop out_ready for 3 cycles -> out_data stays 0x3C, in_ready all 0, rr_ptr frozen; raise out_ready -> next beat is loaded on the same edge the held beat is consumed.
- Boundary: NUM_CH=3, rr_en=0, sel=3 -> in_ready all 0 and out_valid falls after the held beat drains. Assert rst while out_valid=1 -> out_valid=0 next edge.
- Lock (STREAM_MUX_LOCK_EN): ch0 sends a 3-beat packet (in_last on beat 3) while ch1 is valid throughout -> out_ch=0,0,0,1; out_last=1 only on the third beat.
